led_pattern_engine: RTL and testbench

- Downstream consumer of the myLED AXI4-Lite slave register file (slv_reg0..slv_reg3).
- Turns the four 32-bit config words into a timed LED pattern: static, blink, rotate or bounce, with per-LED PWM dimming.
- Sits between the AXI slave and the board LED pins inside the myLED IP top.

---
 rtl/led_pattern_pkg.sv | 22 ++
 rtl/led_pwm_gen.sv | 37 +++
 rtl/led_pattern_engine.sv | 143 ++++++++++++++
 tb/tb_led_pattern_engine.sv | 221 ++++++++++++++++++++++
 4 files changed

// File: rtl/led_pattern_pkg.sv
// Shared types and control-word bit positions for the LED pattern engine.
package led_pattern_pkg;

  typedef enum logic [1:0] {
    MODE_STATIC = 2'b00,
    MODE_BLINK  = 2'b01,
    MODE_ROTATE = 2'b10,
    MODE_BOUNCE = 2'b11
  } mode_e;

  typedef enum logic [1:0] {
    ST_IDLE = 2'b00,
    ST_RUN  = 2'b01,
    ST_HOLD = 2'b10
  } state_e;

  localparam int CTRL_EN       = 0;
  localparam int CTRL_MODE_LSB = 1;
  localparam int CTRL_PWM_EN   = 3;
  localparam int CTRL_ONESHOT  = 4;

endpackage

// File: rtl/led_pwm_gen.sv
// Free-running PWM gate for LED dimming; gate is combinational from the counter.
// LED_GAMMA_EN selects a squared (gamma) duty curve instead of linear duty.
module led_pwm_gen #(
  parameter int PWM_BITS = 8
) (
  input  logic                clk_i,
  input  logic                rst_ni,
  input  logic                pwm_en_i,
  input  logic [PWM_BITS-1:0] duty_i,
  output logic                gate_o
);

  logic [PWM_BITS-1:0] cnt_q, cnt_d;
  logic [PWM_BITS-1:0] duty_eff;

`ifdef LED_GAMMA_EN
  logic [2*PWM_BITS-1:0] duty_sq;
  assign duty_sq  = {{PWM_BITS{1'b0}}, duty_i} * {{PWM_BITS{1'b0}}, duty_i};
  assign duty_eff = PWM_BITS'(duty_sq >> PWM_BITS);
`else
  assign duty_eff = duty_i;
`endif

  assign cnt_d = cnt_q + 1'b1;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) cnt_q <= '0;
    else         cnt_q <= cnt_d;
  end

  // All-ones duty must be fully on, which a strict less-than compare cannot reach.
  always_comb begin
    gate_o = 1'b1;
    if (pwm_en_i && !(&duty_i)) gate_o = (cnt_q < duty_eff);
  end

endmodule

// File: rtl/led_pattern_engine.sv
// Steps a configured LED frame (static/blink/rotate/bounce) on a period prescaler, PWM-gated.
// led is registered (1 cycle after frame/gate); build with LED_GAMMA_EN for gamma-corrected duty.
module led_pattern_engine
  import led_pattern_pkg::*;
#(
  parameter int LED_WIDTH          = 8,
  parameter int C_S_AXI_DATA_WIDTH = 32,
  parameter int PWM_BITS           = 8
) (
  input  logic                          ACLK,
  input  logic                          ARESETN,
  input  logic                          cfg_wr,
  input  logic [C_S_AXI_DATA_WIDTH-1:0] ctrl,
  input  logic [C_S_AXI_DATA_WIDTH-1:0] pattern,
  input  logic [C_S_AXI_DATA_WIDTH-1:0] period,
  input  logic [C_S_AXI_DATA_WIDTH-1:0] duty,
  output logic [LED_WIDTH-1:0]          led,
  output logic                          step_tick,
  output logic                          busy,
  output logic [15:0]                   step_count
);

  localparam int IDXW = (LED_WIDTH > 2) ? $clog2(LED_WIDTH) : 1;
  localparam logic [IDXW-1:0] IDX_MAX = IDXW'(LED_WIDTH - 1);

  state_e               state_q, state_d;
  mode_e                mode_q, mode_d;
  logic [31:0]          presc_q, presc_d;
  logic [LED_WIDTH-1:0] frame_q, frame_d;
  logic [LED_WIDTH-1:0] led_q, led_d;
  logic [15:0]          step_q, step_d;
  logic                 phase_q, phase_d;
  logic [IDXW-1:0]      idx_q, idx_d;
  logic                 up_q, up_d;

  logic                 gate;
  logic                 tick;
  logic                 up_next;
  logic [31:0]          per_last;
  logic [15:0]          limit;
  logic [15:0]          step_inc;
  logic [LED_WIDTH-1:0] disp;
  logic                 unused_cfg;

  assign unused_cfg = ^{ctrl, pattern, duty};

  led_pwm_gen #(.PWM_BITS(PWM_BITS)) u_pwm (
    .clk_i    (ACLK),
    .rst_ni   (ARESETN),
    .pwm_en_i (ctrl[CTRL_PWM_EN]),
    .duty_i   (duty[PWM_BITS-1:0]),
    .gate_o   (gate)
  );

  assign per_last = (period == 32'd0) ? 32'd0 : period - 32'd1;
  assign tick     = (state_q == ST_RUN) && (presc_q == per_last);
  assign limit    = (duty[31:16] == 16'd0) ? 16'd1 : duty[31:16];
  assign step_inc = (step_q == 16'hFFFF) ? step_q : step_q + 16'd1;
  // Reverse at either end so each endpoint is shown for a single step.
  assign up_next  = up_q ? (idx_q != IDX_MAX) : (idx_q == '0);

  always_comb begin
    state_d = state_q;
    mode_d  = mode_q;
    presc_d = presc_q;
    frame_d = frame_q;
    step_d  = step_q;
    phase_d = phase_q;
    idx_d   = idx_q;
    up_d    = up_q;
    if (cfg_wr) begin
      presc_d = '0;
      frame_d = pattern[LED_WIDTH-1:0];
      step_d  = '0;
      phase_d = 1'b1;
      idx_d   = '0;
      up_d    = 1'b1;
      mode_d  = mode_e'(ctrl[CTRL_MODE_LSB +: 2]);
      state_d = ctrl[CTRL_EN] ? ST_RUN : ST_IDLE;
    end else if (!ctrl[CTRL_EN]) begin
      state_d = ST_IDLE;
      presc_d = '0;
    end else if (state_q == ST_RUN) begin
      presc_d = tick ? 32'd0 : presc_q + 32'd1;
      if (tick) begin
        step_d = step_inc;
        case (mode_q)
          MODE_BLINK:  phase_d = ~phase_q;
          MODE_ROTATE: frame_d = {frame_q[LED_WIDTH-2:0], frame_q[LED_WIDTH-1]};
          MODE_BOUNCE: begin
            up_d  = up_next;
            idx_d = up_next ? idx_q + 1'b1 : idx_q - 1'b1;
          end
          default: ;
        endcase
        if (ctrl[CTRL_ONESHOT] && (step_inc >= limit)) state_d = ST_HOLD;
      end
    end
  end

  always_comb begin
    disp = frame_q;
    case (mode_q)
      MODE_BLINK:  disp = phase_q ? frame_q : '0;
      MODE_BOUNCE: begin
        disp        = '0;
        disp[idx_q] = 1'b1;
      end
      default: ;
    endcase
    led_d = (state_q == ST_IDLE) ? '0 : (disp & {LED_WIDTH{gate}});
  end

  always_ff @(posedge ACLK or negedge ARESETN) begin
    if (!ARESETN) begin
      state_q <= ST_IDLE;
      mode_q  <= MODE_STATIC;
      presc_q <= '0;
      frame_q <= '0;
      led_q   <= '0;
      step_q  <= '0;
      phase_q <= 1'b1;
      idx_q   <= '0;
      up_q    <= 1'b1;
    end else begin
      state_q <= state_d;
      mode_q  <= mode_d;
      presc_q <= presc_d;
      frame_q <= frame_d;
      led_q   <= led_d;
      step_q  <= step_d;
      phase_q <= phase_d;
      idx_q   <= idx_d;
      up_q    <= up_d;
    end
  end

  assign led        = led_q;
  assign step_tick  = tick;
  assign busy       = (state_q == ST_RUN);
  assign step_count = step_q;

endmodule

// File: tb/tb_led_pattern_engine.sv
// Self-checking bench for led_pattern_engine against a closed-form pattern model.
module tb_led_pattern_engine;

  logic        ACLK = 1'b0;
  logic        ARESETN;
  logic        cfg_wr;
  logic [31:0] ctrl, pattern, period, duty;
  logic [7:0]  led;
  logic        step_tick, busy;
  logic [15:0] step_count;

  int checks = 0;
  int errors = 0;

  led_pattern_engine #(.LED_WIDTH(8), .C_S_AXI_DATA_WIDTH(32), .PWM_BITS(8)) dut (
    .ACLK       (ACLK),
    .ARESETN    (ARESETN),
    .cfg_wr     (cfg_wr),
    .ctrl       (ctrl),
    .pattern    (pattern),
    .period     (period),
    .duty       (duty),
    .led        (led),
    .step_tick  (step_tick),
    .busy       (busy),
    .step_count (step_count)
  );

  always #5 ACLK = ~ACLK;

  // Displayed frame after n steps, from the pattern rules alone.
  function automatic logic [7:0] model_disp(input int mode, input logic [7:0] pat, input int n);
    logic [15:0] w;
    int k;
    case (mode)
      1: return (n % 2 == 0) ? pat : 8'h00;
      2: begin
        w = {pat, pat} << (n % 8);
        return w[15:8];
      end
      3: begin
        k = n % 14;
        if (k > 7) k = 14 - k;
        return 8'h01 << k;
      end
      default: return pat;
    endcase
  endfunction

  task automatic cyc();
    @(posedge ACLK);
    #1;
  endtask

  task automatic restart(input logic [31:0] c, input logic [31:0] p, input logic [31:0] per,
                         input logic [31:0] d);
    ctrl = c; pattern = p; period = per; duty = d;
    cfg_wr = 1'b1;
    cyc();
    cfg_wr = 1'b0;
  endtask

  task automatic test_reset();
    ARESETN = 1'b0; cfg_wr = 1'b0; ctrl = 0; pattern = 0; period = 0; duty = 0;
    repeat (3) @(posedge ACLK);
    #1;
    checks++; if (led !== 8'h00) begin errors++; $display("FAIL reset_led got %h exp 00", led); end
    checks++; if (step_tick !== 1'b0) begin errors++; $display("FAIL reset_tick got %b exp 0", step_tick); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy got %b exp 0", busy); end
    checks++; if (step_count !== 16'd0) begin errors++; $display("FAIL reset_cnt got %0d exp 0", step_count); end
    ARESETN = 1'b1;
    ctrl = 32'h5; pattern = 32'h1; period = 32'd1;
    repeat (4) cyc();
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_idle_busy got %b exp 0", busy); end
    checks++; if (led !== 8'h00) begin errors++; $display("FAIL reset_idle_led got %h exp 00", led); end
  endtask

  task automatic test_rotate(input logic [7:0] pat, input int p, input int ncyc);
    logic [7:0] e_led;
    logic       e_tick;
    restart(32'h5, {24'hFFFFFF, pat}, p, 32'h0);
    for (int j = 1; j <= ncyc; j++) begin
      cyc();
      e_led  = model_disp(2, pat, (j - 1) / p);
      e_tick = (j % p == p - 1);
      checks++; if (led !== e_led) begin errors++; $display("FAIL rotate_led j=%0d got %h exp %h", j, led, e_led); end
      checks++; if (step_tick !== e_tick) begin errors++; $display("FAIL rotate_tick j=%0d got %b exp %b", j, step_tick, e_tick); end
      checks++; if (step_count !== 16'(j / p)) begin errors++; $display("FAIL rotate_cnt j=%0d got %0d exp %0d", j, step_count, j / p); end
      checks++; if (busy !== 1'b1) begin errors++; $display("FAIL rotate_busy j=%0d got %b exp 1", j, busy); end
    end
  endtask

  task automatic test_blink_oneshot(input logic [7:0] pat, input int p, input int lim);
    logic [7:0] e_led;
    logic       e_busy, e_tick;
    int         n;
    restart(32'h13, {24'h0, pat}, p, {16'(lim), 16'h0003});
    for (int j = 1; j <= (lim + 3) * p + 5; j++) begin
      cyc();
      n      = ((j - 1) / p < lim) ? (j - 1) / p : lim;
      e_led  = model_disp(1, pat, n);
      e_busy = (j / p < lim);
      e_tick = e_busy && (j % p == p - 1);
      checks++; if (led !== e_led) begin errors++; $display("FAIL blink_led j=%0d got %h exp %h", j, led, e_led); end
      checks++; if (busy !== e_busy) begin errors++; $display("FAIL blink_busy j=%0d got %b exp %b", j, busy, e_busy); end
      checks++; if (step_tick !== e_tick) begin errors++; $display("FAIL blink_tick j=%0d got %b exp %b", j, step_tick, e_tick); end
      checks++;
      if (step_count !== 16'((j / p < lim) ? j / p : lim)) begin
        errors++; $display("FAIL blink_cnt j=%0d got %0d exp %0d", j, step_count, (j / p < lim) ? j / p : lim);
      end
    end
  endtask

  task automatic test_bounce(input int p, input int ncyc);
    logic [7:0] e_led;
    restart(32'h7, 32'h0000_00C3, p, 32'h0);
    for (int j = 1; j <= ncyc; j++) begin
      cyc();
      e_led = model_disp(3, 8'h00, (j - 1) / p);
      checks++; if (led !== e_led) begin errors++; $display("FAIL bounce_led j=%0d got %h exp %h", j, led, e_led); end
    end
  endtask

  task automatic test_pwm(input logic [7:0] pat, input logic [7:0] d);
    int on_cnt;
    int e_cnt;
    on_cnt = 0;
`ifdef LED_GAMMA_EN
    e_cnt = (d == 8'hFF) ? 256 : (int'(d) * int'(d)) / 256;
`else
    e_cnt = (d == 8'hFF) ? 256 : int'(d);
`endif
    restart(32'h9, {24'h0, pat}, 32'd3, {24'h0, d});
    repeat (2) cyc();
    for (int j = 0; j < 256; j++) begin
      cyc();
      if (led === pat) on_cnt++;
      checks++;
      if (led !== pat && led !== 8'h00) begin
        errors++; $display("FAIL pwm_level d=%h got %h exp %h or 00", d, led, pat);
      end
    end
    checks++; if (on_cnt != e_cnt) begin errors++; $display("FAIL pwm_ratio d=%h got %0d exp %0d", d, on_cnt, e_cnt); end
  endtask

  task automatic test_restart_priority();
    int p;
    logic [7:0] e_led;
    p = $urandom_range(2, 5);
    restart(32'h5, 32'h01, p, 32'h0);
    for (int j = 1; j <= p - 1; j++) cyc();
    checks++; if (step_tick !== 1'b1) begin errors++; $display("FAIL prio_pre_tick got %b exp 1", step_tick); end
    restart(32'h5, 32'h0F, 32'd0, 32'h0);
    checks++; if (step_count !== 16'd0) begin errors++; $display("FAIL prio_cnt got %0d exp 0", step_count); end
    checks++; if (step_tick !== 1'b1) begin errors++; $display("FAIL prio_tick0 got %b exp 1", step_tick); end
    for (int j = 1; j <= 12; j++) begin
      cyc();
      e_led = model_disp(2, 8'h0F, j - 1);
      checks++; if (led !== e_led) begin errors++; $display("FAIL prio_led j=%0d got %h exp %h", j, led, e_led); end
      checks++; if (step_tick !== 1'b1) begin errors++; $display("FAIL prio_tick j=%0d got %b exp 1", j, step_tick); end
      checks++; if (step_count !== 16'(j)) begin errors++; $display("FAIL prio_cnt j=%0d got %0d exp %0d", j, step_count, j); end
    end
  endtask

  task automatic test_enable_fall();
    restart(32'h5, 32'h81, 32'd2, 32'h0);
    repeat (3) cyc();
    ctrl = 32'h4;
    cyc();
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL enfall_busy got %b exp 0", busy); end
    checks++; if (led === 8'h00) begin errors++; $display("FAIL enfall_led_lag got %h exp nonzero", led); end
    cyc();
    checks++; if (led !== 8'h00) begin errors++; $display("FAIL enfall_led got %h exp 00", led); end
    checks++; if (step_tick !== 1'b0) begin errors++; $display("FAIL enfall_tick got %b exp 0", step_tick); end
    ctrl = 32'h5;
    repeat (4) cyc();
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL enfall_rearm_busy got %b exp 0", busy); end
  endtask

  task automatic test_reset_midrun();
    restart(32'h5, 32'h01, 32'd3, 32'h0);
    for (int j = 1; j <= 5; j++) cyc();
    checks++; if (step_tick !== 1'b1) begin errors++; $display("FAIL midrst_pre_tick got %b exp 1", step_tick); end
    checks++; if (led !== 8'h02) begin errors++; $display("FAIL midrst_pre_led got %h exp 02", led); end
    ARESETN = 1'b0;
    #1;
    checks++; if (led !== 8'h00) begin errors++; $display("FAIL midrst_led got %h exp 00", led); end
    checks++; if (step_tick !== 1'b0) begin errors++; $display("FAIL midrst_tick got %b exp 0", step_tick); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL midrst_busy got %b exp 0", busy); end
    checks++; if (step_count !== 16'd0) begin errors++; $display("FAIL midrst_cnt got %0d exp 0", step_count); end
    cyc();
    ARESETN = 1'b1;
    repeat (5) cyc();
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL midrst_idle_busy got %b exp 0", busy); end
    checks++; if (led !== 8'h00) begin errors++; $display("FAIL midrst_idle_led got %h exp 00", led); end
    restart(32'h5, 32'h01, 32'd3, 32'h0);
    checks++; if (busy !== 1'b1) begin errors++; $display("FAIL midrst_restart_busy got %b exp 1", busy); end
  endtask

  initial begin
    test_reset();
    test_rotate(8'h01, 4, 32);
    repeat (3) test_rotate(8'($urandom_range(1, 255)), $urandom_range(1, 6), 40);
    test_blink_oneshot(8'hA5, 2, 3);
    repeat (2) test_blink_oneshot(8'($urandom_range(1, 255)), $urandom_range(1, 3), $urandom_range(1, 4));
    test_bounce(1, 32);
    test_bounce($urandom_range(2, 3), 40);
    test_pwm(8'hFF, 8'h40);
    test_pwm(8'hFF, 8'hFF);
    test_pwm(8'hFF, 8'h00);
    test_pwm(8'hFF, 8'h80);
    test_pwm(8'hFF, 8'h01);
    repeat (2) test_pwm(8'($urandom_range(1, 255)), 8'($urandom_range(0, 255)));
    test_restart_priority();
    test_enable_fall();
    test_reset_midrun();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
